// File: rtl/meduram_pkg.sv
// meduram_pkg: shared defaults, select-width helper and response record for the read agent port
package meduram_pkg;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NB_WRAGENT = 2;
  localparam int DEF_WRITE_COLLISION = 1;
  localparam int DEF_RAM_LATENCY = 1;
  localparam int DEF_FIFO_DEPTH = 4;
  function automatic int select_width(int nb_wragent, int write_collision);
    return (nb_wragent == 1 ? 1 : $clog2(nb_wragent)) + write_collision;
  endfunction
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic collision;
  } rsp_t;
endpackage

// File: rtl/read_agent_port_if.sv
// read_agent_port_if: request, tracker lookup, bank broadcast and response signals of one read agent
interface read_agent_port_if import meduram_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NB_WRAGENT = DEF_NB_WRAGENT,
  parameter int SELECT_WIDTH = select_width(DEF_NB_WRAGENT, DEF_WRITE_COLLISION)
);
  logic rd_valid;
  logic rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic acc_rden;
  logic [ADDR_WIDTH-1:0] acc_rdaddr;
  logic [SELECT_WIDTH-1:0] acc_select;
  logic bank_rden;
  logic [ADDR_WIDTH-1:0] bank_rdaddr;
  logic [NB_WRAGENT*DATA_WIDTH-1:0] bank_rddata;
  logic rsp_valid;
  logic rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic rsp_collision;
  modport slave (
    input rd_valid, rd_addr, acc_select, bank_rddata, rsp_ready,
    output rd_ready, acc_rden, acc_rdaddr, bank_rden, bank_rdaddr, rsp_valid, rsp_data, rsp_collision
  );
  modport master (
    output rd_valid, rd_addr, acc_select, bank_rddata, rsp_ready,
    input rd_ready, acc_rden, acc_rdaddr, bank_rden, bank_rdaddr, rsp_valid, rsp_data, rsp_collision
  );
endinterface

// File: rtl/read_agent_port_rdrsp_fifo.sv
// rdrsp_fifo: synchronous response FIFO with wrap-bit pointers and async active-high reset
module rdrsp_fifo import meduram_pkg::*; #(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter type T = rsp_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW:0] wptr, rptr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + (AW+1)'(1);
      if (pop && !empty) rptr <= rptr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) if (push && !full) mem[wptr[AW-1:0]] <= din;
  assign dout = mem[rptr[AW-1:0]];
  assign empty = wptr == rptr;
  assign full = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
endmodule

// File: rtl/read_agent_port.sv
// read_agent_port: broadcasts reads to all banks and returns the owning bank's word with a collision flag
module read_agent_port import meduram_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NB_WRAGENT = DEF_NB_WRAGENT,
  parameter int WRITE_COLLISION = DEF_WRITE_COLLISION,
  parameter int RAM_LATENCY = DEF_RAM_LATENCY,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int SELECT_WIDTH = select_width(NB_WRAGENT, WRITE_COLLISION)
) (
  input logic aclk,
  input logic areset,
  read_agent_port_if.slave bus
);
  localparam int IW = SELECT_WIDTH - WRITE_COLLISION;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic collision;
  } rsp_w_t;
  logic [CW-1:0] cnt;
  logic [RAM_LATENCY-1:0] pv;
  logic [SELECT_WIDTH-1:0] ps [RAM_LATENCY];
  logic accept, pop, full, empty, coll;
  logic [IW-1:0] idx;
  rsp_w_t push_rsp, head, held;
  // credits cover both in-flight reads and buffered responses, so the FIFO cannot overflow
  assign bus.rd_ready = !areset && cnt < CW'(FIFO_DEPTH);
  assign accept = bus.rd_valid && bus.rd_ready;
  assign pop = bus.rsp_valid && bus.rsp_ready;
  assign bus.acc_rden = accept;
  assign bus.bank_rden = accept;
  assign bus.acc_rdaddr = bus.rd_addr;
  assign bus.bank_rdaddr = bus.rd_addr;
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt <= '0;
      pv <= '0;
      held <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) ps[i] <= '0;
    end else begin
      cnt <= cnt + CW'(accept) - CW'(pop);
      pv <= (pv << 1) | RAM_LATENCY'(accept);
      ps[0] <= bus.acc_select;
      for (int i = 1; i < RAM_LATENCY; i++) ps[i] <= ps[i-1];
      if (pop) held <= head;
    end
  end
  assign idx = NB_WRAGENT == 1 ? '0 : ps[RAM_LATENCY-1][IW-1:0];
  assign coll = WRITE_COLLISION != 0 && ps[RAM_LATENCY-1][SELECT_WIDTH-1];
  always_comb begin
    push_rsp.data = int'(idx) < NB_WRAGENT ? bus.bank_rddata[int'(idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    push_rsp.collision = coll || int'(idx) >= NB_WRAGENT;
  end
  rdrsp_fifo #(.DEPTH(FIFO_DEPTH), .T(rsp_w_t)) u_fifo (
    .clk(aclk),
    .rst(areset),
    .push(pv[RAM_LATENCY-1]),
    .din(push_rsp),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  // an empty FIFO shows the last popped word rather than a stale slot
  assign bus.rsp_valid = !empty;
  assign bus.rsp_data = empty ? held.data : head.data;
  assign bus.rsp_collision = empty ? held.collision : head.collision;
endmodule

// File: tb/tb_read_agent_port.sv
// tb_read_agent_port: vector table, corner sequences and random traffic against a queue-based model
module tb_read_agent_port;
  typedef struct {
    logic [31:0] data;
    logic coll;
    int vis;
  } exp_t;
  typedef struct {
    logic [7:0] addr;
    logic [1:0] sel;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] exp_data;
    logic exp_coll;
  } vec_t;
  logic clk = 0;
  logic areset = 1;
  always #5 clk = ~clk;
  read_agent_port_if bus();
  read_agent_port dut (.aclk(clk), .areset(areset), .bus(bus.slave));
  logic [31:0] mem [2][256];
  logic [1:0] owner [256];
  logic [31:0] bank_q [2];
  assign bus.acc_select = owner[bus.rd_addr];
  assign bus.bank_rddata = {bank_q[1], bank_q[0]};
  always @(posedge clk) begin
    if (bus.bank_rden) begin
      bank_q[0] <= mem[0][bus.bank_rdaddr];
      bank_q[1] <= mem[1][bus.bank_rdaddr];
    end
  end
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0;
  int accepts = 0, pops = 0, first_pop = 0, last_pop = 0, ready_drops = 0;
  logic [31:0] last = '0;
  logic last_coll = 0;
  vec_t vt [4];
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", n, act, exp, cyc);
    end
  endtask
  // model: every accepted read becomes visible two cycles later, in order, from the owner's bank
  task automatic mon();
    bit er, ev;
    logic [1:0] s;
    exp_t e;
    if (areset) begin
      chk("rst_rd_ready", 32'(bus.rd_ready), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      q.delete();
      last = '0;
    end else begin
      er = q.size() < 4;
      ev = q.size() > 0 && q[0].vis <= cyc;
      chk("rd_ready", 32'(bus.rd_ready), 32'(er));
      if (!bus.rd_ready) ready_drops++;
      chk("bank_rden", 32'(bus.bank_rden), 32'(bus.rd_valid && er));
      chk("acc_rden", 32'(bus.acc_rden), 32'(bus.rd_valid && er));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
      if (ev) begin
        chk("rsp_data", bus.rsp_data, q[0].data);
        chk("rsp_collision", 32'(bus.rsp_collision), 32'(q[0].coll));
        if (bus.rsp_ready) begin
          last = q[0].data;
          last_coll = q[0].coll;
          if (pops == 0) first_pop = cyc;
          last_pop = cyc;
          pops++;
          void'(q.pop_front());
        end
      end else chk("rsp_hold", bus.rsp_data, last);
      if (bus.rd_valid && er) begin
        s = owner[bus.rd_addr];
        e.data = mem[s[0]][bus.rd_addr];
        e.coll = s[1];
        e.vis = cyc + 2;
        q.push_back(e);
        accepts++;
      end
    end
  endtask
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic drain(int n);
    int k = 0;
    bus.rsp_ready = 1;
    while (q.size() > 0 && k < n) begin
      tick();
      k++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask
  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[0][a] = $urandom;
      mem[1][a] = $urandom;
      owner[a] = 2'($urandom);
    end
    vt[0] = '{8'h10, 2'b01, 32'h1111_0000, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0};
    vt[1] = '{8'h20, 2'b11, 32'h2222_0000, 32'hBEEF_0002, 32'hBEEF_0002, 1'b1};
    vt[2] = '{8'h30, 2'b00, 32'h3333_0003, 32'h4444_0000, 32'h3333_0003, 1'b0};
    vt[3] = '{8'h40, 2'b10, 32'h5555_0005, 32'h6666_0000, 32'h5555_0005, 1'b1};
    bus.rd_valid = 0;
    bus.rd_addr = '0;
    bus.rsp_ready = 0;
    repeat (3) tick();
    areset = 0;
    #1 chk("ready_after_release", 32'(bus.rd_ready), 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem[0][vt[i].addr] = vt[i].d0;
      mem[1][vt[i].addr] = vt[i].d1;
      owner[vt[i].addr] = vt[i].sel;
      bus.rd_addr = vt[i].addr;
      bus.rd_valid = 1;
      bus.rsp_ready = 1;
      tick();
      bus.rd_valid = 0;
      drain(10);
      chk("vec_data", last, vt[i].exp_data);
      chk("vec_collision", 32'(last_coll), 32'(vt[i].exp_coll));
    end
    pops = 0;
    ready_drops = 0;
    bus.rsp_ready = 1;
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr = 8'(i * 7 + 3);
      bus.rd_valid = 1;
      tick();
    end
    bus.rd_valid = 0;
    drain(20);
    chk("tput_pops", pops, 16);
    chk("tput_span", last_pop - first_pop, 15);
    chk("tput_ready_drops", ready_drops, 0);
    accepts = 0;
    pops = 0;
    bus.rsp_ready = 0;
    bus.rd_valid = 1;
    for (int i = 0; i < 6; i++) begin
      bus.rd_addr = 8'(8'h80 + i);
      tick();
    end
    chk("bp_accepts", accepts, 4);
    chk("bp_ready_low", 32'(bus.rd_ready), 0);
    bus.rsp_ready = 1;
    #1 chk("full_pop_no_accept", 32'(bus.rd_ready), 0);
    tick();
    chk("full_accepts_held", accepts, 4);
    chk("full_next_ready", 32'(bus.rd_ready), 1);
    for (int k = 0; k < 10 && accepts < 6; k++) tick();
    bus.rd_valid = 0;
    drain(20);
    chk("bp_total_accepts", accepts, 6);
    chk("bp_pops", pops, 6);
    accepts = 0;
    pops = 0;
    bus.rsp_ready = 0;
    bus.rd_valid = 1;
    repeat (3) tick();
    bus.rd_valid = 0;
    chk("midrst_inflight", accepts, 3);
    #2 areset = 1;
    #1;
    chk("midrst_valid_now", 32'(bus.rsp_valid), 0);
    chk("midrst_ready_now", 32'(bus.rd_ready), 0);
    tick();
    tick();
    areset = 0;
    #1 chk("midrst_ready_after", 32'(bus.rd_ready), 1);
    bus.rsp_ready = 1;
    repeat (8) tick();
    chk("midrst_no_stale", pops, 0);
    for (int i = 0; i < 400; i++) begin
      bus.rd_valid = ($urandom_range(0, 3) != 0);
      bus.rd_addr = 8'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.rd_valid = 0;
    drain(50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
